hub75_rx: RTL and testbench
===========================

# hub75_rx

Receive-side HUB75 panel model: oversamples the panel pins (colour data, PANEL_CLK, PANEL_STB, PANEL_OE, row address) on the system clock and rebuilds the shifted row. On each strobe it emits the row as a valid/ready pixel stream. It sits opposite the panel driver, either in a loopback bench or as a panel emulator feeding a framebuffer writer. It checks shift counts and flags strobes that arrive while a previous row is still draining.

## Interface

- WIDTH, 32: columns per half-panel row; shift register depth.
- SYNC_STAGES, 2: synchronizer flops per panel input (≥2).

- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1  in  1 each  colour data, upper (0) and lower (1) half.
- panel_a, panel_b, panel_c, panel_d  in  1 each  row address; addr = {d,c,b,a}.
- panel_clk  in  1  shift clock; a rising edge shifts one column.
- panel_stb  in  1  latch; a rising edge captures the row.
- panel_oe  in  1  output enable, active-low.
- px_valid  out  1  pixel available.
- px_ready  in  1  sink accepts pixel.
- px_row  out  5  panel row 0..31.
- px_col  out  clog2(WIDTH)  column.
- px_rgb  out  3  {r,g,b}.
- blank  out  1  synchronized panel_oe (1 = panel dark).
- overflow  out  1  sticky: strobe arrived while draining.
- count_err  out  1  sticky: a strobe saw a shift count other than WIDTH.

## Operation

- All panel inputs pass through SYNC_STAGES flops. Edge detection compares the last sync stage with one further delayed copy.
- **Shift:** on a panel_clk rising edge, shift {r1,g1,b1,r0,g0,b0} into a WIDTH×6 shift register. The newest entry is column 0; older entries move toward WIDTH-1 and the entry past WIDTH-1 is dropped. shift_cnt increments and saturates at WIDTH+1. Shifting runs in every state.
- **Latch:** on a panel_stb rising edge, behaviour depends on state:
  - IDLE: copy the shift register to the row buffer and latch addr. Set count_err if shift_cnt≠WIDTH. Clear shift_cnt. Go to DRAIN.
  - DRAIN: keep the row buffer unchanged. Set overflow. Still perform the count check and clear shift_cnt.
- **Simultaneous edges:** a panel_clk and panel_stb rising edge detected in the same cycle shift first; the latched row includes the new column and the count check includes it.
- **FSM:**
  - IDLE: px_valid=0.
  - DRAIN, upper half: for cols 0..WIDTH-1, px_row={0,addr}, px_rgb=buffer[col].{r0,g0,b0}.
  - DRAIN, lower half: for cols 0..WIDTH-1, px_row={1,addr}, px_rgb=buffer[col].{r1,g1,b1}.
  - Sequence control: an internal 1+clog2(WIDTH)-bit index; the MSB selects the half. A handshake on the last lower-half pixel returns to IDLE.
- **Handshake:**
  - A pixel transfers when px_valid and px_ready are both 1 on a clock edge.
  - While px_valid=1 and px_ready=0, px_row, px_col and px_rgb hold stable.
  - px_valid never drops without a transfer.
- **blank:** equals the last panel_oe sync stage, with no further processing.
- **Sticky flags:** overflow and count_err clear only on reset.
- **Reset values:** px_valid=0, px_row=0, px_col=0, px_rgb=0, blank=1, overflow=0, count_err=0. Also shift_cnt=0, the shift register and row buffer are zero, FSM=IDLE, and sync/edge flops are 0.
- **Reset mid-DRAIN:** the partial row is discarded and no further pixels are emitted.

## Timing

- **Input pulse widths:** panel_clk and panel_stb must each stay high ≥2 clk and low ≥2 clk. Narrower pulses may be missed; this is not flagged.
- **Data setup:** data and address pins must be stable from ≥SYNC_STAGES+1 clk before a panel_clk/panel_stb rising edge until ≥1 clk after it.
- **Edge-detect latency:** the first clk edge that samples panel_stb=1 is edge 0. The strobe is detected combinationally after edge SYNC_STAGES, the row buffer loads on edge SYNC_STAGES+1, and px_valid=1 after edge SYNC_STAGES+1. For default SYNC_STAGES=2, px_valid rises after edge 3.
- **Throughput:** with px_ready held 1, one pixel per clk. A row drains in exactly 2·WIDTH cycles. px_valid falls after the edge carrying the final transfer.
- **Back-to-back rows:** a strobe detected in the same cycle as the final handshake counts as DRAIN. It sets overflow and is dropped. A strobe detected one cycle later is accepted.
- **blank latency:** blank follows panel_oe with SYNC_STAGES cycles of latency.

## Test plan

- **Reset values:** assert resetn=0 mid-stream. Expect px_valid=0, blank=1, overflow=0, count_err=0 immediately, with no clk edge needed.
- **Full row:**
  - Stimulus: WIDTH=32, shift 32 columns where column k carries r0=k[0], g0=k[1], b0=k[2], r1=!k[0]. Last shifted is k=0. Strobe with addr=5.
  - Expect: 64 pixels. Upper half has px_row=5, px_col=k, px_rgb={k[0],k[1],k[2]}. Lower half has px_row=21 with r=!k[0]. count_err=0.
- **Backpressure:** toggle px_ready randomly during a drain. Expect outputs held while stalled, exactly 64 transfers, order unchanged.
- **Short and long rows:** 31 shifts then strobe, and separately 40 shifts then strobe. Expect count_err=1 in both cases. For 40 shifts, the row holds the last 32 shifted columns.
- **Overflow:** strobe a second row while the first is at pixel 10 with px_ready=1. Expect overflow=1 and the first row's 64 pixels unchanged. The second row is not emitted. Rows shifted afterwards drain normally.
- **Simultaneous edge and mid-drain reset:**
  - Rising panel_clk and panel_stb on the same clk after 31 shifts: count_err=0 and the row includes the 32nd column.
  - Reset during a drain: px_valid=0 immediately and no pixels after release.

Source files
------------

// File: rtl/hub75_rx.sv
`timescale 1ns/1ps
// hub75_rx -- receive-side HUB75 panel model.
//
// Oversamples the HUB75 panel pins on clk, rebuilds the shifted row in a
// WIDTH-deep shift register and, on each strobe, emits the latched row as a
// valid/ready pixel stream: first the upper half (r0,g0,b0), then the lower
// half (r1,g1,b1), columns 0..WIDTH-1 in each half.
//
// Parameters
//   WIDTH        columns per half-panel row (shift register depth, >= 2)
//   SYNC_STAGES  synchronizer flops per panel input (>= 2)
//
// Ports
//   clk, resetn                 system clock / asynchronous active-low reset
//   panel_{r,g,b}{0,1}          colour data, upper (0) and lower (1) half
//   panel_{a,b,c,d}             row address, addr = {d,c,b,a}
//   panel_clk                   shift clock, rising edge shifts one column
//   panel_stb                   latch, rising edge captures the row
//   panel_oe                    output enable, active-low
//   px_valid / px_ready         pixel stream handshake
//   px_row, px_col, px_rgb      pixel coordinates and {r,g,b}
//   blank                       synchronized panel_oe (1 = panel dark)
//   overflow                    sticky: strobe arrived while draining
//   count_err                   sticky: strobe saw a shift count != WIDTH
module hub75_rx #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     panel_r0,
    input  logic                     panel_g0,
    input  logic                     panel_b0,
    input  logic                     panel_r1,
    input  logic                     panel_g1,
    input  logic                     panel_b1,
    input  logic                     panel_a,
    input  logic                     panel_b,
    input  logic                     panel_c,
    input  logic                     panel_d,
    input  logic                     panel_clk,
    input  logic                     panel_stb,
    input  logic                     panel_oe,
    output logic                     px_valid,
    input  logic                     px_ready,
    output logic [4:0]               px_row,
    output logic [$clog2(WIDTH)-1:0] px_col,
    output logic [2:0]               px_rgb,
    output logic                     blank,
    output logic                     overflow,
    output logic                     count_err
);

    localparam int COL_W = $clog2(WIDTH);
    localparam int IDX_W = COL_W + 1;
    localparam int CNT_W = $clog2(WIDTH + 2);
    localparam int NPIN  = 13;

    // Bit positions inside the synchronized pin bundle.
    localparam int PIN_ADDR_LO = 6;
    localparam int PIN_CLK     = 10;
    localparam int PIN_STB     = 11;
    localparam int PIN_OEN     = 12;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Shift count saturates one past a full row so that any over-long row
    // is still distinguishable from an exact one.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + CNT_W'(1);
    endfunction

    // Output enable is carried inverted so that an all-zero reset of the
    // synchronizer leaves blank=1 (panel dark).
    logic [NPIN-1:0] pins;
    assign pins = {~panel_oe, panel_stb, panel_clk,
                   panel_d, panel_c, panel_b, panel_a,
                   panel_r1, panel_g1, panel_b1,
                   panel_r0, panel_g0, panel_b0};

    // ---- synchronizer chain ----
    logic [NPIN-1:0] sync_q [SYNC_STAGES];
    logic [NPIN-1:0] pins_s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= pins;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign pins_s = sync_q[SYNC_STAGES-1];
    assign blank  = ~pins_s[PIN_OEN];

    // ---- stage p0: delayed copy for edge detection ----
    logic clk_p0;
    logic stb_p0;
    // ---- stage p1: registered edge pulses with the data sampled alongside ----
    logic       clk_rise_p1;
    logic       stb_rise_p1;
    logic [5:0] data_p1;
    logic [3:0] addr_p1;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            clk_p0      <= 1'b0;
            stb_p0      <= 1'b0;
            clk_rise_p1 <= 1'b0;
            stb_rise_p1 <= 1'b0;
            data_p1     <= '0;
            addr_p1     <= '0;
        end else begin
            clk_p0      <= pins_s[PIN_CLK];
            stb_p0      <= pins_s[PIN_STB];
            clk_rise_p1 <= pins_s[PIN_CLK] & ~clk_p0;
            stb_rise_p1 <= pins_s[PIN_STB] & ~stb_p0;
            data_p1     <= pins_s[5:0];
            addr_p1     <= pins_s[PIN_ADDR_LO +: 4];
        end
    end

    // ---- stage p2: shift register, row buffer, flags and drain FSM ----
    // Entry layout per column: {r1,g1,b1,r0,g0,b0}; column 0 is newest.
    logic [WIDTH-1:0][5:0] sreg;
    logic [WIDTH-1:0][5:0] sreg_nxt;
    logic [CNT_W-1:0]      shift_cnt;
    logic [CNT_W-1:0]      cnt_nxt;

    // The shift is resolved before the strobe so that a simultaneous
    // panel_clk edge is included both in the latched row and in the count.
    always_comb begin
        sreg_nxt = sreg;
        cnt_nxt  = shift_cnt;
        if (clk_rise_p1) begin
            sreg_nxt = {sreg[WIDTH-2:0], data_p1};
            cnt_nxt  = sat_inc(shift_cnt);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sreg      <= '0;
            shift_cnt <= '0;
        end else begin
            sreg      <= sreg_nxt;
            shift_cnt <= stb_rise_p1 ? '0 : cnt_nxt;
        end
    end

    state_t                state;
    state_t                state_nxt;
    logic                  load;
    logic [WIDTH-1:0][5:0] row_buf;
    logic [3:0]            addr_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  half;
    logic [COL_W-1:0]      col;

    // The index MSB selects the half being drained; the low bits are the column.
    assign half = idx_q[COL_W];
    assign col  = idx_q[COL_W-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        px_valid  = 1'b0;
        px_row    = '0;
        px_col    = '0;
        px_rgb    = '0;
        case (state)
            IDLE: begin
                if (stb_rise_p1) begin
                    load      = 1'b1;
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                px_valid = 1'b1;
                px_row   = {half, addr_q};
                px_col   = col;
                px_rgb   = half ? row_buf[col][5:3] : row_buf[col][2:0];
                if (px_ready && half && (col == COL_LAST)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_buf <= '0;
            addr_q  <= '0;
            idx_q   <= '0;
        end else begin
            if (load) begin
                row_buf <= sreg_nxt;
                addr_q  <= addr_p1;
                idx_q   <= '0;
            end else if (px_valid && px_ready) begin
                // End of a half wraps the column and flips the half; after
                // the final lower-half pixel this lands back on index 0.
                idx_q <= (col == COL_LAST) ? {~half, {COL_W{1'b0}}}
                                           : idx_q + IDX_W'(1);
            end
        end
    end

    // A strobe seen while draining (including on the final handshake cycle)
    // is dropped but still counted and checked.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            count_err <= 1'b0;
        end else begin
            if (stb_rise_p1 && (state == DRAIN)) begin
                overflow <= 1'b1;
            end
            if (stb_rise_p1 && (cnt_nxt != CNT_FULL)) begin
                count_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hub75_rx.sv
`timescale 1ns/1ps
module tb_hub75_rx;

    localparam int W  = 32;
    localparam int SS = 2;
    localparam int CW = $clog2(W);

    logic          clk = 1'b0;
    logic          resetn;
    logic          panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1;
    logic          panel_a, panel_b, panel_c, panel_d;
    logic          panel_clk, panel_stb, panel_oe;
    logic          px_valid;
    logic          px_ready;
    logic [4:0]    px_row;
    logic [CW-1:0] px_col;
    logic [2:0]    px_rgb;
    logic          blank;
    logic          overflow;
    logic          count_err;

    always #5 clk = ~clk;

    hub75_rx #(.WIDTH(W), .SYNC_STAGES(SS)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .panel_r0  (panel_r0),
        .panel_g0  (panel_g0),
        .panel_b0  (panel_b0),
        .panel_r1  (panel_r1),
        .panel_g1  (panel_g1),
        .panel_b1  (panel_b1),
        .panel_a   (panel_a),
        .panel_b   (panel_b),
        .panel_c   (panel_c),
        .panel_d   (panel_d),
        .panel_clk (panel_clk),
        .panel_stb (panel_stb),
        .panel_oe  (panel_oe),
        .px_valid  (px_valid),
        .px_ready  (px_ready),
        .px_row    (px_row),
        .px_col    (px_col),
        .px_rgb    (px_rgb),
        .blank     (blank),
        .overflow  (overflow),
        .count_err (count_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]    row;
        logic [CW-1:0] col;
        logic [2:0]    rgb;
    } px_t;

    logic [5:0] cols[$];      // cols[0] = most recently shifted column
    px_t        exp_q[$];     // pixels still owed by the DUT
    int         shifts;
    bit         ovf_exp;
    bit         cerr_exp;

    function automatic void model_reset();
        cols.delete();
        for (int i = 0; i < W; i++) cols.push_back(6'd0);
        exp_q.delete();
        shifts   = 0;
        ovf_exp  = 0;
        cerr_exp = 0;
    endfunction

    function automatic void model_shift(input logic [5:0] d);
        cols.push_front(d);
        void'(cols.pop_back());
        shifts++;
    endfunction

    function automatic void model_strobe(input logic [3:0] addr);
        px_t p;
        if (shifts != W) cerr_exp = 1;
        shifts = 0;
        if (exp_q.size() != 0) begin
            ovf_exp = 1;       // row still draining: strobe is dropped
        end else begin
            for (int h = 0; h < 2; h++) begin
                for (int c = 0; c < W; c++) begin
                    p.row = {(h == 1), addr};
                    p.col = CW'(c);
                    p.rgb = (h == 1) ? cols[c][5:3] : cols[c][2:0];
                    exp_q.push_back(p);
                end
            end
        end
    endfunction

    // ---------------- pixel monitor ----------------
    int xfer_cnt    = 0;
    int valid_cycles = 0;
    bit stalled_prev = 0;

    always @(negedge clk) begin
        if (resetn) begin
            if (stalled_prev) chk("valid_hold", px_valid, 1);
            if (px_valid) valid_cycles++;
            if (exp_q.size() == 0) begin
                chk("no_px_expected", px_valid, 0);
            end else if (px_valid) begin
                chk("pixel", {px_row, px_col, px_rgb}, exp_q[0]);
                if (px_ready) begin
                    void'(exp_q.pop_front());
                    xfer_cnt++;
                end
            end
            stalled_prev = px_valid && !px_ready;
        end else begin
            stalled_prev = 0;
        end
    end

    // ---------------- ready driver ----------------
    int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled

    initial begin
        px_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       px_ready = 1'b1;
                1:       px_ready = 1'($urandom_range(0, 1));
                default: px_ready = 1'b0;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_addr(input logic [3:0] a);
        {panel_d, panel_c, panel_b, panel_a} = a;
    endtask

    task automatic shift_col(input logic [5:0] d, input bit with_stb, input logic [3:0] addr);
        {panel_r1, panel_g1, panel_b1, panel_r0, panel_g0, panel_b0} = d;
        if (with_stb) set_addr(addr);
        tick(SS + 2);
        panel_clk = 1'b1;
        model_shift(d);
        if (with_stb) begin
            panel_stb = 1'b1;
            model_strobe(addr);
        end
        tick(3);
        panel_clk = 1'b0;
        panel_stb = 1'b0;
        tick(3);
    endtask

    task automatic strobe(input logic [3:0] addr);
        set_addr(addr);
        tick(SS + 2);
        panel_stb = 1'b1;
        model_strobe(addr);
        tick(3);
        panel_stb = 1'b0;
        tick(3);
    endtask

    task automatic shift_random(input int n);
        for (int i = 0; i < n; i++) shift_col(6'($urandom), 0, 4'd0);
    endtask

    task automatic do_reset();
        rdy_mode  = 0;
        resetn    = 1'b0;
        panel_clk = 1'b0;
        panel_stb = 1'b0;
        model_reset();
        tick(2);
        resetn = 1'b1;
        tick(2);
    endtask

    task automatic wait_drain(input string name);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || px_valid) && c < 3000) begin
            tick(1);
            c++;
        end
        chk(name, (c < 3000), 1);
    endtask

    // ---------------- table of row vectors ----------------
    typedef struct {
        int         nshift;
        logic [3:0] addr;
        bit         full_pat;   // column k: r0=k[0] g0=k[1] b0=k[2] r1=!k[0], last shifted k=0
        bit         rand_rdy;
        bit         simul;      // last shift and strobe rise together
        bit         exp_cerr;
    } row_vec_t;

    row_vec_t vecs[6];

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish, required finish before 5ms");
        $fatal(1);
    end

    initial begin
        int         base;
        int         vbase;
        int         c;
        logic [4:0] k;
        logic [5:0] d;

        vecs[0] = '{nshift: 32, addr: 4'd5,  full_pat: 1, rand_rdy: 0, simul: 0, exp_cerr: 0};
        vecs[1] = '{nshift: 32, addr: 4'd9,  full_pat: 0, rand_rdy: 1, simul: 0, exp_cerr: 0};
        vecs[2] = '{nshift: 31, addr: 4'd3,  full_pat: 0, rand_rdy: 0, simul: 0, exp_cerr: 1};
        vecs[3] = '{nshift: 40, addr: 4'd12, full_pat: 0, rand_rdy: 0, simul: 0, exp_cerr: 1};
        vecs[4] = '{nshift: 32, addr: 4'd7,  full_pat: 0, rand_rdy: 0, simul: 1, exp_cerr: 0};
        vecs[5] = '{nshift: 32, addr: 4'd15, full_pat: 0, rand_rdy: 1, simul: 0, exp_cerr: 0};

        resetn = 1'b0;
        {panel_r0, panel_g0, panel_b0, panel_r1, panel_g1, panel_b1} = '0;
        set_addr(4'd0);
        panel_clk = 1'b0;
        panel_stb = 1'b0;
        panel_oe  = 1'b1;
        model_reset();

        // Reset values before any clock edge.
        #2;
        chk("rst_px_valid", px_valid, 0);
        chk("rst_blank", blank, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_count_err", count_err, 0);
        chk("rst_px_out", {px_row, px_col, px_rgb}, 0);
        tick(2);
        resetn = 1'b1;
        tick(2);

        // blank follows panel_oe after SS edges.
        panel_oe = 1'b0;
        for (int i = 1; i <= SS; i++) begin
            tick(1);
            chk("blank_fall_lat", blank, (i < SS) ? 1 : 0);
        end
        panel_oe = 1'b1;
        for (int i = 1; i <= SS; i++) begin
            tick(1);
            chk("blank_rise_lat", blank, (i < SS) ? 0 : 1);
        end

        // Strobe to px_valid latency: valid after edge SS+1 (edge 0 samples stb=1).
        do_reset();
        shift_random(W);
        set_addr(4'd1);
        tick(SS + 2);
        panel_stb = 1'b1;
        model_strobe(4'd1);
        for (int i = 1; i <= SS + 2; i++) begin
            tick(1);
            chk("valid_latency", px_valid, (i >= SS + 2) ? 1 : 0);
        end
        tick(1);
        panel_stb = 1'b0;
        wait_drain("latency_drain");
        chk("latency_cerr", count_err, 0);

        // Table-driven rows.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            rdy_mode = vecs[v].rand_rdy ? 1 : 0;
            base  = xfer_cnt;
            vbase = valid_cycles;
            for (int i = 0; i < vecs[v].nshift; i++) begin
                if (vecs[v].full_pat) begin
                    k = 5'(vecs[v].nshift - 1 - i);
                    d = {~k[0], 1'b0, 1'b0, k[0], k[1], k[2]};
                end else begin
                    d = 6'($urandom);
                end
                shift_col(d, vecs[v].simul && (i == vecs[v].nshift - 1), vecs[v].addr);
            end
            if (!vecs[v].simul) strobe(vecs[v].addr);
            wait_drain("row_drain");
            chk("row_xfers", xfer_cnt - base, 2 * W);
            if (!vecs[v].rand_rdy) chk("row_valid_cycles", valid_cycles - vbase, 2 * W);
            chk("row_count_err", count_err, vecs[v].exp_cerr);
            chk("row_overflow", overflow, 0);
        end

        // Overflow: second strobe while the first row is around pixel 10.
        do_reset();
        shift_random(W);
        base = xfer_cnt;
        strobe(4'd4);
        c = 0;
        while ((xfer_cnt - base) < 10 && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk("ovf_reach_px10", (c < 500), 1);
        rdy_mode = 2;
        shift_random(W);
        rdy_mode = 0;
        strobe(4'd11);
        chk("ovf_flag", overflow, ovf_exp);
        chk("ovf_count_err", count_err, cerr_exp);
        wait_drain("ovf_drain1");
        chk("ovf_first_row_xfers", xfer_cnt - base, 2 * W);
        shift_random(W);
        strobe(4'd2);
        wait_drain("ovf_drain2");
        chk("ovf_next_row_xfers", xfer_cnt - base, 4 * W);
        chk("ovf_sticky", overflow, 1);

        // Reset in the middle of a drain.
        do_reset();
        panel_oe = 1'b0;
        rdy_mode = 1;
        shift_random(W);
        strobe(4'd6);
        tick(10);
        chk("mid_blank_on", blank, 0);
        chk("mid_valid", px_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", px_valid, 0);
        chk("mid_rst_blank", blank, 1);
        chk("mid_rst_overflow", overflow, 0);
        chk("mid_rst_count_err", count_err, 0);
        model_reset();
        base = xfer_cnt;
        tick(1);
        resetn = 1'b1;
        rdy_mode = 0;
        tick(100);
        chk("post_rst_valid", px_valid, 0);
        chk("post_rst_xfers", xfer_cnt - base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
